// File: rtl/fifo_feeder_pkg.sv
// fifo_feeder_pkg: shared types and default widths for the FIFO write-side feeder.
//
// Contents:
//   DefDataWidth   - default stream/FIFO data width
//   DefCntWidth    - default statistics counter width (stats build only)
//   feeder_state_e - feeder FSM states (StRun, StHalt)
package fifo_feeder_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefCntWidth  = 16;

  typedef enum logic {
    StRun  = 1'b0,
    StHalt = 1'b1
  } feeder_state_e;

endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: two-entry valid/ready buffer with a registered ready and a head/pop
// interface. Slot 0 always holds the oldest word (the head); slot 1 the next.
//
// Ports:
//   clk_i        - clock, rising edge
//   rst_i        - synchronous active-high reset (empties the buffer, ready low)
//   in_valid_i   - upstream word valid
//   in_data_i    - upstream word
//   in_ready_o   - registered: buffer can take a word this cycle
//   head_valid_o - buffer holds at least one word
//   head_data_o  - oldest buffered word
//   pop_i        - consume the head this cycle (ignored when empty)
module skid_buf2 #(
  parameter int unsigned DataWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 in_ready_o,
  output logic                 head_valid_o,
  output logic [DataWidth-1:0] head_data_o,
  input  logic                 pop_i
);

  logic [DataWidth-1:0] slot0_q, slot0_d;
  logic [DataWidth-1:0] slot1_q, slot1_d;
  logic [1:0]           count_q, count_d;
  logic                 ready_q, ready_d;
  logic                 push;
  logic                 pop;

  // ready_q is only high when count_q < 2, so a push can never overrun.
  assign push = in_valid_i && ready_q;
  assign pop  = pop_i && (count_q != 2'd0);

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          slot0_d = in_data_i;
        end else begin
          slot1_d = in_data_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new word lands behind whatever remains.
        if (count_q == 2'd1) begin
          slot0_d = in_data_i;
        end else begin
          slot0_d = slot1_q;
          slot1_d = in_data_i;
        end
      end
      default: ;
    endcase
    // Ready for next cycle reflects occupancy after this cycle's push/pop.
    ready_d = (count_d < 2'd2);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready_o   = ready_q;
  assign head_valid_o = (count_q != 2'd0);
  assign head_data_o  = slot0_q;

endmodule

// File: rtl/fifo_wr_feeder.sv
// fifo_wr_feeder: write-side feeder in front of a synchronous FIFO. Buffers an
// upstream valid/ready stream in a 2-entry skid buffer, issues FIFO writes while
// the FIFO is not full, and checks each write against wr_ack/overflow one cycle
// later. A failed check halts writing and latches the failing word until
// clear_err is pulsed.
//
// Optional feature macro: FIFO_WR_FEEDER_STATS_EN adds the CNT_WIDTH parameter
// and the saturating wr_count / stall_count / err_count outputs.
//
// Ports:
//   clk, rst      - clock (rising edge), synchronous active-high reset
//   s_valid/s_data/s_ready - upstream stream (s_ready is registered)
//   wr_en, data_in        - FIFO write port (wr_en combinational)
//   full, wr_ack, overflow - FIFO status/response
//   clear_err     - single-cycle pulse, leaves HALT
//   err, err_data - sticky error flag and the first failing word
//   wr_count, stall_count, err_count - statistics (stats build only)
module fifo_wr_feeder
  import fifo_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth
`ifdef FIFO_WR_FEEDER_STATS_EN
  ,
  parameter int unsigned CNT_WIDTH  = DefCntWidth
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic                  full,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  clear_err,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] err_data
`ifdef FIFO_WR_FEEDER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic [CNT_WIDTH-1:0]  err_count
`endif
);

  feeder_state_e         state_q, state_d;
  logic                  issued_q;
  logic [DATA_WIDTH-1:0] last_q;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] err_data_q, err_data_d;

  logic                  head_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  check_fail;
  logic                  fail;
  logic                  good;

  skid_buf2 #(
    .DataWidth (DATA_WIDTH)
  ) u_skid (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (s_valid),
    .in_data_i    (s_data),
    .in_ready_o   (s_ready),
    .head_valid_o (head_valid),
    .head_data_o  (head_data),
    .pop_i        (wr_en)
  );

  assign wr_en   = (state_q == StRun) && head_valid && !full;
  assign data_in = head_data;

  // The write issued last cycle is checked regardless of the current state, so a
  // write issued just before HALT is still verified.
  assign check_fail = issued_q && (!wr_ack || overflow);
  assign fail       = check_fail || (!issued_q && overflow);
  assign good       = issued_q && wr_ack && !overflow;

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    err_data_d = err_data_q;
    if (fail) begin
      // Failure wins over a simultaneous clear_err.
      state_d = StHalt;
      err_d   = 1'b1;
      // Keep the first failing word; a stray overflow has no word to report.
      if (check_fail && !err_q) begin
        err_data_d = last_q;
      end
    end else if ((state_q == StHalt) && clear_err) begin
      state_d = StRun;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      issued_q   <= 1'b0;
      last_q     <= '0;
      err_q      <= 1'b0;
      err_data_q <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= wr_en;
      last_q     <= data_in;
      err_q      <= err_d;
      err_data_q <= err_data_d;
    end
  end

  assign err      = err_q;
  assign err_data = err_data_q;

`ifdef FIFO_WR_FEEDER_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic                 stall;

  assign stall = head_valid && full && (state_q == StRun);

  always_comb begin
    wr_count_d    = wr_count_q;
    stall_count_d = stall_count_q;
    err_count_d   = err_count_q;
    if (good && (wr_count_q != CntMax)) begin
      wr_count_d = wr_count_q + CntOne;
    end
    if (stall && (stall_count_q != CntMax)) begin
      stall_count_d = stall_count_q + CntOne;
    end
    if (fail && (err_count_q != CntMax)) begin
      err_count_d = err_count_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q    <= '0;
      stall_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      wr_count_q    <= wr_count_d;
      stall_count_q <= stall_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign wr_count    = wr_count_q;
  assign stall_count = stall_count_q;
  assign err_count   = err_count_q;
`endif

endmodule
